// File: rtl/cva6_hpdcache_store_buffer_if.sv
// ---------------------------------------------------------------------------
// cva6_hpdcache_store_buffer_if
//
// Bundles every handshake/bus signal of the store buffer. Clock and reset
// stay plain module ports.
//
// Signal groups:
//   st_*        store request from the CVA6 store unit (valid/ready)
//   dc_*        head-of-queue store towards the HPDcache adapter (req/gnt)
//   core_amo_*  AMO request (level) / completion pulse on the core side
//   dc_amo_*    AMO request / ack towards the adapter
//   ld_*        load address and byte enables for the overlap check, ld_hit result
//   empty       no buffered store and no AMO in progress (used for fences)
//
// Modports:
//   slave  - the store buffer itself
//   master - the environment (store unit + adapter + load unit)
// ---------------------------------------------------------------------------
interface cva6_hpdcache_store_buffer_if #(
    parameter int unsigned PLEN = 56,
    parameter int unsigned XLEN = 64
);
    logic                  st_valid;
    logic                  st_ready;
    logic [PLEN-1:0]       st_addr;
    logic [XLEN-1:0]       st_wdata;
    logic [XLEN/8-1:0]     st_be;
    logic [1:0]            st_size;

    logic                  dc_req;
    logic                  dc_gnt;
    logic [PLEN-1:0]       dc_addr;
    logic [XLEN-1:0]       dc_wdata;
    logic [XLEN/8-1:0]     dc_be;
    logic [1:0]            dc_size;

    logic                  core_amo_req;
    logic                  core_amo_ack;
    logic                  dc_amo_req;
    logic                  dc_amo_ack;

    logic [PLEN-1:0]       ld_addr;
    logic [XLEN/8-1:0]     ld_be;
    logic                  ld_hit;

    logic                  empty;

    modport slave (
        input  st_valid, st_addr, st_wdata, st_be, st_size,
        output st_ready,
        output dc_req, dc_addr, dc_wdata, dc_be, dc_size,
        input  dc_gnt,
        input  core_amo_req,
        output core_amo_ack,
        output dc_amo_req,
        input  dc_amo_ack,
        input  ld_addr, ld_be,
        output ld_hit,
        output empty
    );

    modport master (
        output st_valid, st_addr, st_wdata, st_be, st_size,
        input  st_ready,
        input  dc_req, dc_addr, dc_wdata, dc_be, dc_size,
        output dc_gnt,
        output core_amo_req,
        input  core_amo_ack,
        input  dc_amo_req,
        output dc_amo_ack,
        output ld_addr, ld_be,
        input  ld_hit,
        input  empty
    );
endinterface

// File: rtl/cva6_hpdcache_store_buffer.sv
// ---------------------------------------------------------------------------
// cva6_hpdcache_store_buffer
//
// In-order store queue between the CVA6 store unit and the store/AMO port
// of the HPDcache adapter. Committed stores are queued and drained one per
// grant. An AMO waits until every older store has been granted, then is
// issued to the adapter. Loads overlapping a buffered store raise ld_hit so
// the load unit can stall.
//
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset
//   bus     cva6_hpdcache_store_buffer_if.slave (store, drain, AMO, load-hazard, empty)
// ---------------------------------------------------------------------------
module cva6_hpdcache_store_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PLEN  = 56,
    parameter int unsigned XLEN  = 64
) (
    input  logic clk_i,
    input  logic rst_ni,
    cva6_hpdcache_store_buffer_if.slave bus
);
    localparam int unsigned BE_W  = XLEN / 8;
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned OFF_W = $clog2(BE_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        AMO   = 2'd2
    } state_e;

    state_e             state_reg, state_next;
    logic               amo_req_reg;

    logic [PTR_W-1:0]   rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]   count_reg, count_next;

    // Entry storage; validity is derived from the pointers and count, so the
    // payload itself needs no reset.
    logic [PLEN-1:0]    addr_mem  [DEPTH];
    logic [XLEN-1:0]    wdata_mem [DEPTH];
    logic [BE_W-1:0]    be_mem    [DEPTH];
    logic [1:0]         size_mem  [DEPTH];

    logic               st_ready;
    logic               empty;
    logic               core_amo_ack;
    logic               dc_req;
    logic               push, pop;
    logic [DEPTH-1:0]   hit_vec;

    // Byte-offset bits of the load address do not take part in the overlap
    // check (the byte enables cover them).
    logic               unused_ld_offset;
    assign unused_ld_offset = ^bus.ld_addr[OFF_W-1:0];

    assign dc_req = (count_reg != '0);
    assign push   = bus.st_valid & st_ready;
    assign pop    = dc_req & bus.dc_gnt;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= IDLE;
            amo_req_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            // Registered so the adapter sees the request from the first AMO cycle.
            amo_req_reg <= (state_next == AMO);
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.core_amo_req)     state_next = DRAIN;
            DRAIN:   if (count_reg == '0)      state_next = AMO;
            AMO:     if (bus.dc_amo_ack)       state_next = IDLE;
            default:                           state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // st_ready looks only at registered state: a pop in the same cycle as a
    // full queue does not open a slot until the next cycle.
    always_comb begin
        st_ready     = (count_reg != CNT_W'(DEPTH)) && (state_reg == IDLE);
        empty        = (count_reg == '0) && (state_reg == IDLE);
        core_amo_ack = bus.dc_amo_ack && (state_reg == AMO);
    end

    // ---------------- FIFO pointers and occupancy ----------------
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem[wr_ptr_reg]  <= bus.st_addr;
            wdata_mem[wr_ptr_reg] <= bus.st_wdata;
            be_mem[wr_ptr_reg]    <= bus.st_be;
            size_mem[wr_ptr_reg]  <= bus.st_size;
        end
    end

    // ---------------- Load overlap check ----------------
    // An entry is live when its distance from the read pointer is below the
    // count. Entries leaving this cycle are still live here, so a load never
    // slips past a store that has not yet been written into the cache.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
            logic [PTR_W-1:0] rel;
            logic             live;
            assign rel         = PTR_W'(gi) - rd_ptr_reg;
            assign live        = (CNT_W'(rel) < count_reg);
            assign hit_vec[gi] = live
                              && (addr_mem[gi][PLEN-1:OFF_W] == bus.ld_addr[PLEN-1:OFF_W])
                              && ((be_mem[gi] & bus.ld_be) != '0);
        end
    endgenerate

    // ---------------- Interface outputs ----------------
    assign bus.st_ready     = st_ready;
    assign bus.dc_req       = dc_req;
    assign bus.dc_addr      = addr_mem[rd_ptr_reg];
    assign bus.dc_wdata     = wdata_mem[rd_ptr_reg];
    assign bus.dc_be        = be_mem[rd_ptr_reg];
    assign bus.dc_size      = size_mem[rd_ptr_reg];
    assign bus.dc_amo_req   = amo_req_reg;
    assign bus.core_amo_ack = core_amo_ack;
    assign bus.ld_hit       = |hit_vec;
    assign bus.empty        = empty;

    // A store and an AMO must never be offered to the adapter together.
    a_no_store_amo_overlap: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(dc_req && amo_req_reg)
    );
endmodule

// File: tb/tb_cva6_hpdcache_store_buffer.sv
module tb_cva6_hpdcache_store_buffer;
    localparam int DEPTH = 4;
    localparam int PLEN  = 56;
    localparam int XLEN  = 64;
    localparam int BE_W  = XLEN / 8;

    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    cva6_hpdcache_store_buffer_if #(.PLEN(PLEN), .XLEN(XLEN)) bus_if ();

    cva6_hpdcache_store_buffer #(.DEPTH(DEPTH), .PLEN(PLEN), .XLEN(XLEN)) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus_if.slave)
    );

    typedef struct packed {
        logic [PLEN-1:0] addr;
        logic [XLEN-1:0] data;
        logic [BE_W-1:0] be;
        logic [1:0]      size;
    } st_t;

    st_t sb[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drained-store monitor: the handshake completes at the next posedge.
    always @(negedge clk_i) begin : mon
        st_t e;
        if (rst_ni && bus_if.dc_req && bus_if.dc_gnt) begin
            check_eq("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check_eq("dc_addr", 64'(bus_if.dc_addr), 64'(e.addr));
                check_eq("dc_wdata", 64'(bus_if.dc_wdata), 64'(e.data));
                check_eq("dc_be", 64'(bus_if.dc_be), 64'(e.be));
                check_eq("dc_size", 64'(bus_if.dc_size), 64'(e.size));
            end
            $display("store out: addr=0x%0h data=0x%0h be=0x%0h", bus_if.dc_addr, bus_if.dc_wdata, bus_if.dc_be);
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One store attempt; st_valid stays asserted on return.
    task automatic push(input logic [PLEN-1:0] a, input logic [XLEN-1:0] d, input logic [BE_W-1:0] b,
                        output bit acc, output bit req_seen);
        bus_if.st_valid = 1'b1;
        bus_if.st_addr  = a;
        bus_if.st_wdata = d;
        bus_if.st_be    = b;
        bus_if.st_size  = 2'd3;
        @(negedge clk_i);
        acc      = bus_if.st_ready;
        req_seen = bus_if.dc_req;
        if (acc) sb.push_back('{addr: a, data: d, be: b, size: 2'd3});
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_wait(input logic [PLEN-1:0] a, input logic [XLEN-1:0] d);
        bit acc, req;
        acc = 1'b0;
        for (int t = 0; t < 20; t++) begin
            push(a, d, 8'hFF, acc, req);
            if (acc) break;
            bus_if.dc_gnt = 1'b1;
        end
        check_eq("push_accept", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        bus_if.dc_gnt = 1'b1;
        for (int t = 0; t < 60; t++) begin
            if (sb.size() == 0 && !bus_if.dc_req) break;
            tick();
        end
        check_eq("drain_sb_empty", 64'(sb.size()), 64'd0);
        check_eq("drain_req_low", 64'(bus_if.dc_req), 64'd0);
        bus_if.dc_gnt = 1'b0;
    endtask

    task automatic ld_check(input string tag, input logic [PLEN-1:0] a, input logic [BE_W-1:0] b, input bit exp);
        bus_if.ld_addr = a;
        bus_if.ld_be   = b;
        @(negedge clk_i);
        check_eq(tag, 64'(bus_if.ld_hit), 64'(exp));
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc, req;
        rst_ni              = 1'b0;
        bus_if.st_valid     = 1'b0;
        bus_if.st_addr      = '0;
        bus_if.st_wdata     = '0;
        bus_if.st_be        = '0;
        bus_if.st_size      = '0;
        bus_if.dc_gnt       = 1'b0;
        bus_if.core_amo_req = 1'b0;
        bus_if.dc_amo_ack   = 1'b0;
        bus_if.ld_addr      = '0;
        bus_if.ld_be        = '0;

        // Reset values (checked before any clock edge: reset is asynchronous)
        #1;
        check_eq("rst_st_ready", 64'(bus_if.st_ready), 64'd1);
        check_eq("rst_empty", 64'(bus_if.empty), 64'd1);
        check_eq("rst_dc_req", 64'(bus_if.dc_req), 64'd0);
        check_eq("rst_amo_req", 64'(bus_if.dc_amo_req), 64'd0);
        check_eq("rst_amo_ack", 64'(bus_if.core_amo_ack), 64'd0);
        check_eq("rst_ld_hit", 64'(bus_if.ld_hit), 64'd0);
        repeat (2) @(posedge clk_i);
        #3 rst_ni = 1'b1;
        tick();

        // 1: three stores, grant always high
        bus_if.dc_gnt = 1'b1;
        push(56'h1000, 64'hA0, 8'hFF, acc, req);
        check_eq("t1_accept0", 64'(acc), 64'd1);
        check_eq("t1_no_fallthrough", 64'(req), 64'd0);
        check_eq("t1_req_rise", 64'(bus_if.dc_req), 64'd1);
        push(56'h1008, 64'hA1, 8'hFF, acc, req);
        push(56'h1010, 64'hA2, 8'hFF, acc, req);
        bus_if.st_valid = 1'b0;
        check_eq("t1_not_empty", 64'(bus_if.empty), 64'd0);
        tick();
        check_eq("t1_empty", 64'(bus_if.empty), 64'd1);
        check_eq("t1_sb_empty", 64'(sb.size()), 64'd0);

        // 2: fill to DEPTH, full + pop does not admit a push
        bus_if.dc_gnt = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            push(56'h3000 + 56'(8 * i), 64'(48 + i), 8'hFF, acc, req);
            check_eq("t2_accept", 64'(acc), 64'd1);
        end
        check_eq("t2_full_not_ready", 64'(bus_if.st_ready), 64'd0);
        bus_if.dc_gnt = 1'b1;
        push(56'h3020, 64'h34, 8'hFF, acc, req);
        bus_if.dc_gnt = 1'b0;
        check_eq("t2_no_push_when_full", 64'(acc), 64'd0);
        check_eq("t2_ready_after_pop", 64'(bus_if.st_ready), 64'd1);
        push(56'h3020, 64'h34, 8'hFF, acc, req);
        check_eq("t2_fifth_accept", 64'(acc), 64'd1);
        bus_if.st_valid = 1'b0;
        drain();

        // 3: AMO waits behind two older stores
        push(56'h4000, 64'h40, 8'hFF, acc, req);
        push(56'h4008, 64'h41, 8'hFF, acc, req);
        bus_if.st_valid = 1'b0;
        bus_if.core_amo_req = 1'b1;
        tick();
        check_eq("t3_drain_not_ready", 64'(bus_if.st_ready), 64'd0);
        check_eq("t3_amo_wait0", 64'(bus_if.dc_amo_req), 64'd0);
        bus_if.dc_amo_ack = 1'b1;
        @(negedge clk_i);
        check_eq("t3_stray_ack_ignored", 64'(bus_if.core_amo_ack), 64'd0);
        tick();
        bus_if.dc_amo_ack = 1'b0;
        check_eq("t3_amo_wait1", 64'(bus_if.dc_amo_req), 64'd0);
        bus_if.dc_gnt = 1'b1;
        tick();
        check_eq("t3_amo_wait2", 64'(bus_if.dc_amo_req), 64'd0);
        tick();
        check_eq("t3_amo_wait3", 64'(bus_if.dc_amo_req), 64'd0);
        check_eq("t3_stores_gone", 64'(bus_if.dc_req), 64'd0);
        tick();
        bus_if.dc_gnt = 1'b0;
        check_eq("t3_amo_req", 64'(bus_if.dc_amo_req), 64'd1);
        bus_if.dc_amo_ack = 1'b1;
        @(negedge clk_i);
        check_eq("t3_amo_ack", 64'(bus_if.core_amo_ack), 64'd1);
        tick();
        bus_if.dc_amo_ack   = 1'b0;
        bus_if.core_amo_req = 1'b0;
        check_eq("t3_amo_req_drop", 64'(bus_if.dc_amo_req), 64'd0);
        check_eq("t3_ready_back", 64'(bus_if.st_ready), 64'd1);
        check_eq("t3_ack_single", 64'(bus_if.core_amo_ack), 64'd0);
        check_eq("t3_empty", 64'(bus_if.empty), 64'd1);

        // 4: load hazard check
        push(56'h2008, 64'h0000_0000_DEAD_BEEF, 8'h0F, acc, req);
        bus_if.st_valid = 1'b0;
        ld_check("t4_be_disjoint", 56'h2008, 8'hF0, 1'b0);
        ld_check("t4_be_overlap", 56'h2008, 8'h01, 1'b1);
        ld_check("t4_other_word", 56'h2010, 8'h0F, 1'b0);
        ld_check("t4_same_word_offset", 56'h200C, 8'h0F, 1'b1);
        bus_if.ld_addr = 56'h2008;
        bus_if.ld_be   = 8'h01;
        bus_if.dc_gnt  = 1'b1;
        @(negedge clk_i);
        check_eq("t4_hit_while_pop", 64'(bus_if.ld_hit), 64'd1);
        tick();
        bus_if.dc_gnt = 1'b0;
        check_eq("t4_no_hit_after_pop", 64'(bus_if.ld_hit), 64'd0);

        // 5a: asynchronous reset with stores queued during DRAIN
        push(56'h5000, 64'h50, 8'hFF, acc, req);
        push(56'h5008, 64'h51, 8'hFF, acc, req);
        push(56'h5010, 64'h52, 8'hFF, acc, req);
        bus_if.st_valid = 1'b0;
        bus_if.core_amo_req = 1'b1;
        tick();
        check_eq("t5_pre_req", 64'(bus_if.dc_req), 64'd1);
        #2 rst_ni = 1'b0;
        #1;
        sb.delete();
        check_eq("t5_rst_dc_req", 64'(bus_if.dc_req), 64'd0);
        check_eq("t5_rst_amo_req", 64'(bus_if.dc_amo_req), 64'd0);
        check_eq("t5_rst_empty", 64'(bus_if.empty), 64'd1);
        check_eq("t5_rst_ready", 64'(bus_if.st_ready), 64'd1);
        bus_if.core_amo_req = 1'b0;
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        tick();
        check_eq("t5_post_dc_req", 64'(bus_if.dc_req), 64'd0);
        check_eq("t5_post_empty", 64'(bus_if.empty), 64'd1);
        ld_check("t5_no_stale_hit", 56'h5008, 8'hFF, 1'b0);
        push(56'h5100, 64'h5A, 8'hFF, acc, req);
        bus_if.st_valid = 1'b0;
        drain();

        // 5b: asynchronous reset while in AMO with the ack pending
        bus_if.core_amo_req = 1'b1;
        tick();
        tick();
        check_eq("t5_in_amo", 64'(bus_if.dc_amo_req), 64'd1);
        bus_if.dc_amo_ack = 1'b1;
        #1;
        check_eq("t5_ack_before_rst", 64'(bus_if.core_amo_ack), 64'd1);
        #1 rst_ni = 1'b0;
        #1;
        check_eq("t5_rst_amo_ack", 64'(bus_if.core_amo_ack), 64'd0);
        check_eq("t5_rst_amo_req2", 64'(bus_if.dc_amo_req), 64'd0);
        check_eq("t5_rst_empty2", 64'(bus_if.empty), 64'd1);
        bus_if.core_amo_req = 1'b0;
        bus_if.dc_amo_ack   = 1'b0;
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        tick();
        check_eq("t5_post_amo_req", 64'(bus_if.dc_amo_req), 64'd0);
        check_eq("t5_post_ready", 64'(bus_if.st_ready), 64'd1);

        // 6: wrap-around with toggling grant, data 0..9
        for (int i = 0; i < 10; i++) begin
            bus_if.dc_gnt = (i % 2) == 1;
            push_wait(56'h6000 + 56'(8 * i), 64'(i));
        end
        bus_if.st_valid = 1'b0;
        drain();

        check_eq("end_sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
